pipeline_sequencer: RTL and testbench

// Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable and flush inputs of
// the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves load-use hazards, taken branches
// (resolved in MEM) and variable-latency data-memory accesses (req/ready). It keeps saturating

---
 rtl/pipeline_seq_if.sv | 44 ++++
 rtl/pipeline_sequencer.sv | 135 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_seq_if.sv
// Control bundle between the MIPS pipeline datapath and the stall/flush sequencer.
interface pipeline_seq_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_writereg;
  logic             mem_branch;
  logic             mem_zero;
  logic             mem_rd;
  logic             mem_wr;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_en;
  logic             pc_src;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath side: supplies hazard/memory status, consumes enables and flushes.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_writereg,
           mem_branch, mem_zero, mem_rd, mem_wr, dmem_ready,
    input  dmem_req, pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, mem_timeout, stall_cnt, flush_cnt
  );

  // Sequencer side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_writereg,
           mem_branch, mem_zero, mem_rd, mem_wr, dmem_ready,
    output dmem_req, pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls, MEM-resolved
// branch flushes, variable-latency data-memory freeze with timeout trap, perf counters.
module pipeline_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_seq_if.slave   bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic acc, br, lu;
  logic pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, dmem_req, mem_timeout;

  assign acc = bus.mem_rd | bus.mem_wr;
  assign br  = bus.mem_branch & bus.mem_zero;
  assign lu  = bus.ex_memread && (bus.ex_writereg != 5'd0) &&
               ((bus.ex_writereg == bus.id_rs) ||
                (bus.id_uses_rt && (bus.ex_writereg == bus.id_rt)));

  // Next state, wait/perf counters and control outputs.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    dmem_req    = 1'b0;
    mem_timeout = 1'b0;

    case (state_q)
      RUN, MEM_WAIT: begin
        dmem_req = (state_q == MEM_WAIT) | acc;
        if (state_q == MEM_WAIT && !bus.dmem_ready) begin
          if (wait_q == WAIT_W'(TIMEOUT_CYCLES)) begin
            state_d = ERR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else if (state_q == RUN && acc && !bus.dmem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          // Access complete (or none): normal pipeline advance with branch > load-use.
          state_d  = RUN;
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (br) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            if (flush_q != {CNT_W{1'b1}}) flush_d = flush_q + CNT_W'(1);
          end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
        if (!pc_en && stall_q != {CNT_W{1'b1}}) stall_d = stall_q + CNT_W'(1);
      end
      ERR: begin
        mem_timeout = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Asynchronous reset forces every control output low immediately.
    if (reset) begin
      pc_en       = 1'b0;
      pc_src      = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      dmem_req    = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.pc_src      = pc_src;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_en    = memwb_en;
  assign bus.dmem_req    = dmem_req;
  assign bus.mem_timeout = mem_timeout;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: per-cycle expected control vectors and counter checks.
module tb_pipeline_sequencer;

  localparam int unsigned CNT_W = 4;

  // Control vector order: {pc_en, pc_src, ifid_en, ifid_flush, idex_en, idex_flush,
  //                        exmem_en, exmem_flush, memwb_en, dmem_req, mem_timeout}
  localparam logic [10:0] E_RST     = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] E_RUN     = 11'b1_0_1_0_1_0_1_0_1_0_0;
  localparam logic [10:0] E_RUN_REQ = 11'b1_0_1_0_1_0_1_0_1_1_0;
  localparam logic [10:0] E_FREEZE  = 11'b0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] E_LU      = 11'b0_0_0_0_1_1_1_0_1_0_0;
  localparam logic [10:0] E_LU_REQ  = 11'b0_0_0_0_1_1_1_0_1_1_0;
  localparam logic [10:0] E_BR      = 11'b1_1_1_1_1_1_1_1_1_0_0;
  localparam logic [10:0] E_ERR     = 11'b0_0_0_0_0_0_0_0_0_0_1;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  sb_entry_t sb_q[$];

  pipeline_seq_if #(.CNT_W(CNT_W)) bus ();

  pipeline_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ctl();
    return {bus.pc_en, bus.pc_src, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
            bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.dmem_req, bus.mem_timeout};
  endfunction

  task automatic idle();
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_uses_rt  = 1'b0;
    bus.ex_memread  = 1'b0;
    bus.ex_writereg = 5'd0;
    bus.mem_branch  = 1'b0;
    bus.mem_zero    = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses_rt);
    bus.ex_memread  = 1'b1;
    bus.ex_writereg = wr;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_uses_rt  = uses_rt;
  endtask

  // Inputs are already driven (posedge+1); queue expectation, sample before the next edge.
  task automatic cyc(input string tag, input logic [10:0] exp);
    sb_entry_t e;
    sb_q.push_back('{tag, exp});
    #3;
    e = sb_q.pop_front();
    check(e.tag, 32'(ctl()), 32'(e.exp));
    @(posedge clk);
    #1;
  endtask

  task automatic counters(input string tag, input int stall, input int flush);
    check({tag, "_stall"}, 32'(bus.stall_cnt), 32'(stall));
    check({tag, "_flush"}, 32'(bus.flush_cnt), 32'(flush));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.mem_rd = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_outputs", E_RST);
    counters("rst", 0, 0);
    reset = 1'b0;
    idle();

    cyc("idle", E_RUN);

    // Zero-wait read
    bus.mem_rd = 1'b1; bus.dmem_ready = 1'b1;
    cyc("zero_wait_rd", E_RUN_REQ);
    counters("zero_wait", 0, 0);

    // Write with three wait cycles
    idle();
    bus.mem_wr = 1'b1;
    for (int i = 0; i < 3; i++) cyc($sformatf("wr_wait%0d", i), E_FREEZE);
    bus.dmem_ready = 1'b1;
    cyc("wr_done", E_RUN_REQ);
    idle();
    cyc("after_wr_run", E_RUN);
    counters("wr_wait", 3, 0);

    // Load-use hazards
    load_use(5'd8, 5'd8, 5'd0, 1'b0);
    cyc("lu_rs", E_LU);
    load_use(5'd0, 5'd0, 5'd0, 1'b1);
    cyc("lu_r0", E_RUN);
    load_use(5'd9, 5'd3, 5'd9, 1'b1);
    cyc("lu_rt", E_LU);
    load_use(5'd9, 5'd3, 5'd9, 1'b0);
    cyc("lu_rt_unused", E_RUN);
    counters("lu", 5, 0);

    // Taken branch overrides a load-use match; untaken branch does nothing
    load_use(5'd8, 5'd8, 5'd0, 1'b0);
    bus.mem_branch = 1'b1; bus.mem_zero = 1'b1;
    cyc("br_over_lu", E_BR);
    idle();
    bus.mem_branch = 1'b1;
    cyc("br_untaken", E_RUN);
    counters("br", 5, 1);

    // Load-use stall in the cycle a waited read completes
    idle();
    bus.mem_rd = 1'b1;
    cyc("rd_wait", E_FREEZE);
    bus.dmem_ready = 1'b1;
    load_use(5'd4, 5'd4, 5'd0, 1'b0);
    cyc("rd_done_lu", E_LU_REQ);
    idle();
    cyc("after_rd_lu", E_RUN);
    counters("wait_lu", 7, 1);

    // Stall counter saturation
    load_use(5'd8, 5'd8, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) cyc($sformatf("sat_lu%0d", i), E_LU);
    counters("sat", 15, 1);

    // Reset in the middle of a memory wait
    idle();
    bus.mem_rd = 1'b1;
    cyc("abort_wait0", E_FREEZE);
    cyc("abort_wait1", E_FREEZE);
    #1 reset = 1'b1;
    #1 check("abort_outputs", 32'(ctl()), 32'(E_RST));
    counters("abort", 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    cyc("abort_back_run", E_RUN);

    // Timeout: one RUN freeze plus four MEM_WAIT cycles, then ERR
    bus.mem_rd = 1'b1;
    for (int i = 0; i < 5; i++) cyc($sformatf("to_wait%0d", i), E_FREEZE);
    cyc("err0", E_ERR);
    idle();
    bus.mem_branch = 1'b1; bus.mem_zero = 1'b1; bus.dmem_ready = 1'b1;
    cyc("err_sticky", E_ERR);
    counters("err", 5, 0);
    idle();
    reset = 1'b1;
    #1 check("err_reset_outputs", 32'(ctl()), 32'(E_RST));
    counters("err_reset", 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("err_reset_run", E_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
